// File: rtl/pixel_window_gen.sv
// pixel_window_gen: streaming 3x3 window generator over a raster-order 24bpp
// pixel stream. Two line buffers hold the previous two rows; every interior
// pixel produces one 216-bit window. Border pixels produce no window.
//
// Ports:
//   clk, n_rst        clock, synchronous active-low reset
//   sof               start of frame, marks pixel (0,0), qualified by pixel_valid
//   pixel_in[23:0]    pixel {R,G,B}
//   pixel_valid       pixel_in/sof valid
//   pixel_ready       pixel accepted this cycle (output register has room)
//   pixelData[215:0]  window, MSB slot (r-1,c-1) .. LSB slot (r+1,c+1)
//   frame_valid       pixelData holds a window
//   frame_ready       consumer takes the window
//   center_row/col    centre coordinates of the window
//   frame_done        one-cycle pulse after the last window of an image is taken
//   window_count      (only with PIXEL_WINDOW_GEN_COUNT_EN) windows handed off
//
// Optional feature macro: PIXEL_WINDOW_GEN_COUNT_EN

module pixel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          sof,
  input  logic [23:0]                   pixel_in,
  input  logic                          pixel_valid,
  output logic                          pixel_ready,
  output logic [215:0]                  pixelData,
  output logic                          frame_valid,
  input  logic                          frame_ready,
  output logic [$clog2(IMG_HEIGHT)-1:0] center_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  center_col,
  output logic                          frame_done
`ifdef PIXEL_WINDOW_GEN_COUNT_EN
  , output logic [$clog2(IMG_WIDTH*IMG_HEIGHT):0] window_count
`endif
);

  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [71:0]     cola_q, cola_d;   // older column {top, mid, bot}
  logic [71:0]     colb_q, colb_d;   // newer column {top, mid, bot}
  logic [215:0]    data_q, data_d;
  logic            fv_q, fv_d;
  logic [RW-1:0]   crow_q, crow_d;
  logic [CW-1:0]   ccol_q, ccol_d;
  logic            last_q, last_d;   // output register holds the final window
  logic            done_q, done_d;

  logic [23:0]     lb1_q [IMG_WIDTH];
  logic [23:0]     lb2_q [IMG_WIDTH];

  logic            accept;
  logic            take;
  logic            emit;
  logic            handoff;
  logic [CW-1:0]   lb_col;
  logic [23:0]     lb1_rd;
  logic [23:0]     lb2_rd;
  logic [215:0]    window;

  assign pixel_ready = !(fv_q && !frame_ready);
  assign accept      = pixel_valid && pixel_ready;
  assign handoff     = fv_q && frame_ready;

  // Pixels in IDLE/DONE without sof are discarded and touch nothing.
  assign take = accept && (sof || state_q == S_FILL || state_q == S_STREAM);

  // An sof pixel is column 0 regardless of where the aborted image stood.
  assign lb_col = sof ? '0 : col_q;
  assign lb1_rd = lb1_q[lb_col];
  assign lb2_rd = lb2_q[lb_col];

  assign emit = take && !sof && state_q == S_STREAM &&
                row_q >= ROW_TWO && col_q >= COL_TWO;

  assign window = {cola_q[71:48], colb_q[71:48], lb2_rd,
                   cola_q[47:24], colb_q[47:24], lb1_rd,
                   cola_q[23:0],  colb_q[23:0],  pixel_in};

  always_ff @(posedge clk) begin
    if (take) begin
      lb1_q[lb_col] <= pixel_in;
      lb2_q[lb_col] <= lb1_rd;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cola_d  = cola_q;
    colb_d  = colb_q;
    data_d  = data_q;
    fv_d    = fv_q;
    crow_d  = crow_q;
    ccol_d  = ccol_q;
    last_d  = last_q;
    done_d  = handoff && last_q;

    if (handoff) begin
      fv_d   = 1'b0;
      last_d = 1'b0;
    end

    if (take) begin
      cola_d = colb_q;
      colb_d = {lb2_rd, lb1_rd, pixel_in};

      if (sof) begin
        state_d = S_FILL;
        row_d   = '0;
        col_d   = COL_ONE;
      end else begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + ROW_ONE;
        end else begin
          col_d = col_q + COL_ONE;
        end

        case (state_q)
          S_FILL: begin
            if (row_q == ROW_ONE && col_q == COL_LAST) state_d = S_STREAM;
          end
          S_STREAM: begin
            if (row_q == ROW_LAST && col_q == COL_LAST) begin
              state_d = S_DONE;
              row_d   = '0;
              col_d   = '0;
            end
          end
          default: ;
        endcase
      end
    end

    // Same-cycle load overrides the handoff clear (back-to-back windows).
    if (emit) begin
      data_d = window;
      fv_d   = 1'b1;
      crow_d = row_q - ROW_ONE;
      ccol_d = col_q - COL_ONE;
      last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cola_q  <= '0;
      colb_q  <= '0;
      data_q  <= '0;
      fv_q    <= 1'b0;
      crow_q  <= '0;
      ccol_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cola_q  <= cola_d;
      colb_q  <= colb_d;
      data_q  <= data_d;
      fv_q    <= fv_d;
      crow_q  <= crow_d;
      ccol_q  <= ccol_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign pixelData   = data_q;
  assign frame_valid = fv_q;
  assign center_row  = crow_q;
  assign center_col  = ccol_q;
  assign frame_done  = done_q;

`ifdef PIXEL_WINDOW_GEN_COUNT_EN
  localparam int NW = $clog2(IMG_WIDTH*IMG_HEIGHT) + 1;

  logic [NW-1:0] cnt_q;

  // An accepted sof takes priority over a coincident handoff.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else if (accept && sof) begin
      cnt_q <= '0;
    end else if (handoff) begin
      cnt_q <= cnt_q + NW'(1);
    end
  end

  assign window_count = cnt_q;
`endif

endmodule

// File: tb/tb_pixel_window_gen.sv
module tb_pixel_window_gen;

  localparam int W = 5;
  localparam int H = 4;

  logic         clk;
  logic         n_rst;
  logic         sof;
  logic [23:0]  pixel_in;
  logic         pixel_valid;
  logic         pixel_ready;
  logic [215:0] pixelData;
  logic         frame_valid;
  logic         frame_ready;
  logic [1:0]   center_row;
  logic [2:0]   center_col;
  logic         frame_done;
`ifdef PIXEL_WINDOW_GEN_COUNT_EN
  logic [5:0]   window_count;
`endif

  pixel_window_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .sof         (sof),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .pixelData   (pixelData),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .center_row  (center_row),
    .center_col  (center_col),
    .frame_done  (frame_done)
`ifdef PIXEL_WINDOW_GEN_COUNT_EN
    , .window_count(window_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Handoff monitor: records every window taken by the consumer.
  logic [215:0] q_data[$];
  int           q_row[$];
  int           q_col[$];
  int           cyc      = 0;
  int           last_ho  = 0;
  int           done_cnt = 0;
  int           done_cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (n_rst && frame_valid && frame_ready) begin
      q_data.push_back(pixelData);
      q_row.push_back(int'(center_row));
      q_col.push_back(int'(center_col));
      last_ho <= cyc;
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  function automatic logic [23:0] pix(int r, int c, int img);
    logic [7:0] rb, cb, k;
    rb = 8'(r);
    cb = 8'(c);
    k  = 8'(img * 90);
    return {rb, cb, (rb ^ cb) ^ k};
  endfunction

  function automatic logic [215:0] exp_win(int r, int c, int img);
    logic [215:0] w;
    w = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        w = {w[191:0], pix(r + dr, c + dc, img)};
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_pixel(input int r, input int c, input int img, input bit s);
    bit ok;
    ok          = 1'b0;
    pixel_in    = pix(r, c, img);
    sof         = s;
    pixel_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (pixel_ready) ok = 1'b1;
      step();
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_pixel: pixel (%0d,%0d) not accepted within 50 cycles", r, c);
    end
    pixel_valid = 1'b0;
    sof         = 1'b0;
  endtask

  task automatic send_image(input int img);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pixel(r, c, img, (r == 0 && c == 0));
  endtask

  task automatic test_reset();
    n_rst       = 1'b0;
    sof         = 1'b0;
    pixel_valid = 1'b0;
    pixel_in    = '0;
    frame_ready = 1'b1;
    idle(2);
    n_checks += 6;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
    if (pixel_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", pixel_ready); end
    if (pixelData !== 216'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", pixelData); end
    if (center_row !== 2'd0) begin n_fail++; $display("FAIL reset_row: got %0d expected 0", center_row); end
    if (center_col !== 3'd0) begin n_fail++; $display("FAIL reset_col: got %0d expected 0", center_col); end
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_idle_discard();
    int b;
    b = q_data.size();
    for (int i = 0; i < 7; i++) send_pixel(i / W, i % W, 3, 1'b0);
    idle(5);
    n_checks++;
    if (q_data.size() - b !== 0) begin
      n_fail++; $display("FAIL discard_count: got %0d windows expected 0", q_data.size() - b);
    end
    b = q_data.size();
    send_image(2);
    idle(8);
    n_checks++;
    if (q_data.size() - b !== 6) begin
      n_fail++; $display("FAIL discard_img_count: got %0d expected 6", q_data.size() - b);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (q_data[b+i] !== exp_win(1 + i / 3, 1 + i % 3, 2)) begin
        n_fail++; $display("FAIL discard_win%0d: got %h expected %h", i, q_data[b+i], exp_win(1 + i / 3, 1 + i % 3, 2));
      end
    end
  endtask

  task automatic test_basic();
    int b, d0;
    b  = q_data.size();
    d0 = done_cnt;
    send_image(0);
    idle(8);
    n_checks++;
    if (q_data.size() - b !== 6) begin
      n_fail++; $display("FAIL basic_count: got %0d expected 6", q_data.size() - b);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks += 3;
      if (q_row[b+i] !== 1 + i / 3) begin
        n_fail++; $display("FAIL basic_row%0d: got %0d expected %0d", i, q_row[b+i], 1 + i / 3);
      end
      if (q_col[b+i] !== 1 + i % 3) begin
        n_fail++; $display("FAIL basic_col%0d: got %0d expected %0d", i, q_col[b+i], 1 + i % 3);
      end
      if (q_data[b+i] !== exp_win(1 + i / 3, 1 + i % 3, 0)) begin
        n_fail++; $display("FAIL basic_win%0d: got %h expected %h", i, q_data[b+i], exp_win(1 + i / 3, 1 + i % 3, 0));
      end
    end
    n_checks += 2;
    if (done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - d0);
    end
    if (done_cyc !== last_ho + 1) begin
      n_fail++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, last_ho + 1);
    end
  endtask

  task automatic test_stall();
    int b, d0;
    b  = q_data.size();
    d0 = done_cnt;
    fork
      send_image(0);
      begin
        logic [215:0] held;
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
          if (frame_valid) seen = 1'b1;
          else step();
        end
        n_checks++;
        if (!seen) begin
          n_fail++; $display("FAIL stall_wait: frame_valid got 0 expected 1 within 200 cycles");
        end
        held        = pixelData;
        frame_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          n_checks += 2;
          if (pixel_ready !== 1'b0) begin
            n_fail++; $display("FAIL stall_ready%0d: got %b expected 0", k, pixel_ready);
          end
          if (pixelData !== held) begin
            n_fail++; $display("FAIL stall_hold%0d: got %h expected %h", k, pixelData, held);
          end
          step();
        end
        frame_ready = 1'b1;
      end
    join
    idle(8);
    n_checks++;
    if (q_data.size() - b !== 6) begin
      n_fail++; $display("FAIL stall_count: got %0d expected 6", q_data.size() - b);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (q_data[b+i] !== exp_win(1 + i / 3, 1 + i % 3, 0)) begin
        n_fail++; $display("FAIL stall_win%0d: got %h expected %h", i, q_data[b+i], exp_win(1 + i / 3, 1 + i % 3, 0));
      end
    end
    n_checks++;
    if (done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL stall_done_count: got %0d expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_abort();
    int b, d0;
    b  = q_data.size();
    d0 = done_cnt;
    // Image 1 up to (2,2); its (2,3) slot is replaced by the sof of image 4.
    for (int i = 0; i < 2 * W + 3; i++) send_pixel(i / W, i % W, 1, (i == 0));
    send_image(4);
    idle(8);
    n_checks++;
    if (q_data.size() - b !== 7) begin
      n_fail++; $display("FAIL abort_count: got %0d expected 7", q_data.size() - b);
    end
    n_checks += 3;
    if (q_data[b] !== exp_win(1, 1, 1)) begin
      n_fail++; $display("FAIL abort_pending: got %h expected %h", q_data[b], exp_win(1, 1, 1));
    end
    if (q_row[b+1] !== 1 || q_col[b+1] !== 1) begin
      n_fail++; $display("FAIL abort_first_centre: got (%0d,%0d) expected (1,1)", q_row[b+1], q_col[b+1]);
    end
    if (done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL abort_done_count: got %0d expected 1", done_cnt - d0);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (q_data[b+1+i] !== exp_win(1 + i / 3, 1 + i % 3, 4)) begin
        n_fail++; $display("FAIL abort_win%0d: got %h expected %h", i, q_data[b+1+i], exp_win(1 + i / 3, 1 + i % 3, 4));
      end
    end
  endtask

  task automatic test_midreset();
    int b;
    for (int i = 0; i < 2 * W + 3; i++) send_pixel(i / W, i % W, 5, (i == 0));
    n_checks++;
    if (frame_valid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre_fv: got %b expected 1", frame_valid);
    end
    n_rst = 1'b0;
    step();
    n_checks += 5;
    if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_fv: got %b expected 0", frame_valid); end
    if (pixel_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b expected 1", pixel_ready); end
    if (pixelData !== 216'd0) begin n_fail++; $display("FAIL midreset_data: got %h expected 0", pixelData); end
    if (center_row !== 2'd0 || center_col !== 3'd0) begin
      n_fail++; $display("FAIL midreset_centre: got (%0d,%0d) expected (0,0)", center_row, center_col);
    end
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", frame_done); end
    n_rst = 1'b1;
    step();
    b = q_data.size();
    send_image(6);
    idle(8);
    n_checks++;
    if (q_data.size() - b !== 6) begin
      n_fail++; $display("FAIL midreset_count: got %0d expected 6", q_data.size() - b);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (q_data[b+i] !== exp_win(1 + i / 3, 1 + i % 3, 6)) begin
        n_fail++; $display("FAIL midreset_win%0d: got %h expected %h", i, q_data[b+i], exp_win(1 + i / 3, 1 + i % 3, 6));
      end
    end
  endtask

  task automatic test_count();
`ifdef PIXEL_WINDOW_GEN_COUNT_EN
    n_checks++;
    if (window_count !== 6'd6) begin
      n_fail++; $display("FAIL count_final: got %0d expected 6", window_count);
    end
    send_pixel(0, 0, 7, 1'b1);
    n_checks++;
    if (window_count !== 6'd0) begin
      n_fail++; $display("FAIL count_sof_clear: got %0d expected 0", window_count);
    end
    idle(2);
`endif
  endtask

  initial begin
    test_reset();
    test_idle_discard();
    test_basic();
    test_stall();
    test_abort();
    test_midreset();
    test_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
